// File: rtl/uart_pkg.sv
// Shared definitions for the board UART: receiver state encoding and the
// 19200-baud timing constants used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam logic [11:0] BAUD_CNT_19200 = 12'd2604;
  localparam logic [11:0] HALF_CNT_19200 = 12'd1302;

endpackage

// File: rtl/uart_rx_if.sv
// Parallel side of the UART receiver: received byte, status flags and the
// consumer acknowledge.
interface uart_rx_if;

  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;
  logic       ovr_err;

  modport master (
    input  clr_rdy,
    output rx_data,
    output rdy,
    output frm_err,
    output ovr_err
  );

  modport slave (
    output clr_rdy,
    input  rx_data,
    input  rdy,
    input  frm_err,
    input  ovr_err
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the RX pin plus a delayed copy for falling-edge
// detection. All flops reset high so reset never produces a false start edge.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic rx_meta_reg;
  logic rx_s_reg;
  logic rx_prev_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_s_reg    <= rx_meta_reg;
      rx_prev_reg <= rx_s_reg;
    end
  end

  assign rx_s = rx_s_reg;
  assign fall = rx_prev_reg & ~rx_s_reg;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: samples mid-bit, shifts LSB first and presents each good
// byte with a rdy/clr_rdy handshake plus framing and overrun status.
module uart_rx
  import uart_pkg::*;
#(
  parameter logic [11:0] BAUD_CNT = BAUD_CNT_19200,
  parameter logic [11:0] HALF_CNT = HALF_CNT_19200
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      RX,
  uart_rx_if.master rx_bus
);

  rx_state_t   state_reg, state_next;
  logic [11:0] baud_cnt_reg, baud_cnt_next, baud_inc;
  logic [3:0]  bit_cnt_reg, bit_cnt_next;
  logic [7:0]  shift_reg, shift_next;
  logic [7:0]  rx_data_reg, rx_data_next;
  logic        rdy_reg, rdy_next;
  logic        frm_err_reg, frm_err_next;
  logic        ovr_err_reg, ovr_err_next;
  logic        unread_reg, unread_next;
  logic        rx_s, fall;
  logic        start_det, half_tick, bit_tick, good_stop, bad_stop;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (RX),
    .rx_s (rx_s),
    .fall (fall)
  );

  // A tick fires on the cycle whose increment would bring baud_cnt to the
  // target, so consecutive samples are exactly BAUD_CNT cycles apart.
  assign baud_inc  = baud_cnt_reg + 12'd1;
  assign start_det = (state_reg == IDLE) && fall;
  assign half_tick = (state_reg == START) && (baud_inc == HALF_CNT);
  assign bit_tick  = ((state_reg == DATA) || (state_reg == STOP)) && (baud_inc == BAUD_CNT);
  assign good_stop = (state_reg == STOP) && bit_tick && rx_s;
  assign bad_stop  = (state_reg == STOP) && bit_tick && !rx_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_det) state_next = START;
      START:   if (half_tick) state_next = rx_s ? IDLE : DATA;
      DATA:    if (bit_tick && (bit_cnt_reg == 4'd7)) state_next = STOP;
      STOP:    if (bit_tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    baud_cnt_next = baud_inc;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    rx_data_next  = rx_data_reg;
    frm_err_next  = bad_stop;

    if ((state_reg == IDLE) || half_tick || bit_tick) baud_cnt_next = 12'd0;
    if (half_tick) bit_cnt_next = 4'd0;
    if ((state_reg == DATA) && bit_tick) begin
      shift_next   = {rx_s, shift_reg[7:1]};
      bit_cnt_next = bit_cnt_reg + 4'd1;
    end
    if (good_stop) rx_data_next = shift_reg;

    rdy_next = rdy_reg;
    if (good_stop)      rdy_next = 1'b1;
    else if (start_det) rdy_next = 1'b0;
    else if (rx_bus.clr_rdy) rdy_next = 1'b0;

    // The start edge drops rdy before the consumer may have read the byte;
    // unread remembers that so the next good frame still reports an overrun.
    unread_next = unread_reg;
    if (start_det && rdy_reg && !rx_bus.clr_rdy) unread_next = 1'b1;
    else if (rx_bus.clr_rdy || good_stop)        unread_next = 1'b0;

    ovr_err_next = ovr_err_reg;
    if (good_stop && (rdy_reg || unread_reg)) ovr_err_next = 1'b1;
    else if (rx_bus.clr_rdy)                  ovr_err_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt_reg <= 12'd0;
      bit_cnt_reg  <= 4'd0;
      shift_reg    <= 8'h00;
      rx_data_reg  <= 8'h00;
      rdy_reg      <= 1'b0;
      frm_err_reg  <= 1'b0;
      ovr_err_reg  <= 1'b0;
      unread_reg   <= 1'b0;
    end else begin
      baud_cnt_reg <= baud_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      rx_data_reg  <= rx_data_next;
      rdy_reg      <= rdy_next;
      frm_err_reg  <= frm_err_next;
      ovr_err_reg  <= ovr_err_next;
      unread_reg   <= unread_next;
    end
  end

  assign rx_bus.rx_data = rx_data_reg;
  assign rx_bus.rdy     = rdy_reg;
  assign rx_bus.frm_err = frm_err_reg;
  assign rx_bus.ovr_err = ovr_err_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a fast-baud instance for the functional scenarios and a
// default-baud instance for the full-rate latency check.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int S_BAUD = 32;
  localparam int S_HALF = 16;
  localparam int F_BAUD = 2604;
  localparam int S_LAT  = S_HALF + 9 * S_BAUD + 2;
  localparam int F_LAT  = 24740;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_line_s = 1'b1;
  logic rx_line_f = 1'b1;

  always #10 clk = ~clk;

  uart_rx_if bus_s ();
  uart_rx_if bus_f ();

  uart_rx #(.BAUD_CNT(12'd32), .HALF_CNT(12'd16)) dut (
    .clk    (clk),
    .rst    (rst),
    .RX     (rx_line_s),
    .rx_bus (bus_s.master)
  );

  uart_rx dut_full (
    .clk    (clk),
    .rst    (rst),
    .RX     (rx_line_f),
    .rx_bus (bus_f.master)
  );

  int vecs = 0;
  int errs = 0;

  // monitors, sampled on the falling edge
  int      rises_s = 0, frm_s = 0, frm_long_s = 0, rises_f = 0, frm_f = 0;
  realtime rise_t_s, rise_t_f, t_fall;
  logic    prev_rdy_s = 1'b0, prev_frm_s = 1'b0, prev_rdy_f = 1'b0, prev_frm_f = 1'b0;

  always @(negedge clk) begin
    if (bus_s.rdy && !prev_rdy_s) begin rises_s++; rise_t_s = $realtime; end
    if (bus_s.frm_err && !prev_frm_s) frm_s++;
    if (bus_s.frm_err && prev_frm_s) frm_long_s++;
    if (bus_f.rdy && !prev_rdy_f) begin rises_f++; rise_t_f = $realtime; end
    if (bus_f.frm_err && !prev_frm_f) frm_f++;
    prev_rdy_s = bus_s.rdy;
    prev_frm_s = bus_s.frm_err;
    prev_rdy_f = bus_f.rdy;
    prev_frm_f = bus_f.frm_err;
  end

  // reference model of the consumer-visible state (small instance)
  logic [7:0] m_data = 8'h00;
  bit m_rdy = 0, m_ovr = 0, m_unacked = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".data"}, bus_s.rx_data, m_data);
    check({tag, ".rdy"},  bus_s.rdy, m_rdy);
    check({tag, ".ovr"},  bus_s.ovr_err, m_ovr);
  endtask

  task automatic model_clear();
    m_rdy = 0; m_ovr = 0; m_unacked = 0;
  endtask

  // One frame as seen by the consumer; clr_c is the cycle (from the RX fall)
  // on which clr_rdy was high, -1 for none. A good completion beats clr_rdy.
  task automatic model_frame(input logic [7:0] b, input bit ok, input int clr_c);
    m_rdy = 0;
    if (clr_c >= 0 && clr_c < S_LAT) model_clear();
    if (clr_c == S_LAT && !ok) model_clear();
    if (ok) begin
      if (m_unacked) m_ovr = 1;
      m_unacked = 1;
      m_data = b;
      m_rdy = 1;
    end
    if (clr_c > S_LAT) model_clear();
  endtask

  task automatic send(input bit full, input logic [7:0] b, input bit stop_ok,
                      input int clr_c, input int abort_c);
    int baud;
    logic [9:0] frame;
    baud  = full ? F_BAUD : S_BAUD;
    frame = {stop_ok, b, 1'b0};
    for (int c = 0; c < 10 * baud; c++) begin
      if (c == abort_c) begin
        rst = 1'b1;
        rx_line_s = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (c == 0) t_fall = $realtime;
      if (full) rx_line_f = frame[c / baud];
      else begin
        rx_line_s = frame[c / baud];
        bus_s.clr_rdy = (c == clr_c);
      end
      @(negedge clk);
    end
    bus_s.clr_rdy = 1'b0;
  endtask

  task automatic clr_pulse();
    bus_s.clr_rdy = 1'b1;
    @(negedge clk);
    bus_s.clr_rdy = 1'b0;
    @(negedge clk);
    model_clear();
  endtask

  function automatic int edge_cycles(input realtime t_obs, input realtime t0);
    return int'($floor((t_obs - t0 - 10.0) / 20.0));
  endfunction

  initial begin
    int f0, r0, fl0, lat;
    logic [7:0] bytes3 [3];
    bytes3[0] = 8'h00; bytes3[1] = 8'hFF; bytes3[2] = 8'h3C;
    bus_s.clr_rdy = 1'b0;
    bus_f.clr_rdy = 1'b0;

    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst.data", bus_s.rx_data, 8'h00);
    check("rst.rdy", bus_s.rdy, 1'b0);
    check("rst.frm", bus_s.frm_err, 1'b0);
    check("rst.ovr", bus_s.ovr_err, 1'b0);
    check("rst.f.data", bus_f.rx_data, 8'h00);
    check("rst.f.rdy", bus_f.rdy, 1'b0);
    check("rst.f.frm", bus_f.frm_err, 1'b0);
    check("rst.f.ovr", bus_f.ovr_err, 1'b0);
    repeat (5) @(negedge clk);

    // loopback
    f0 = frm_s; r0 = rises_s;
    send(0, 8'hA5, 1, -1, -1);
    model_frame(8'hA5, 1, -1);
    check_model("loop");
    check("loop.rises", rises_s - r0, 1);
    check("loop.frm", frm_s - f0, 0);
    clr_pulse();

    // back-to-back with acknowledge after each
    r0 = rises_s;
    for (int i = 0; i < 3; i++) begin
      send(0, bytes3[i], 1, -1, -1);
      model_frame(bytes3[i], 1, -1);
      if (i == 0) begin
        lat = edge_cycles(rise_t_s, t_fall);
        check("b2b.latency", (lat >= S_LAT - 1 && lat <= S_LAT + 1) ? S_LAT : lat, S_LAT);
      end
      check_model("b2b");
      clr_pulse();
      check("b2b.clr.rdy", bus_s.rdy, 1'b0);
    end
    check("b2b.rises", rises_s - r0, 3);

    // glitch shorter than half a bit
    f0 = frm_s;
    rx_line_s = 1'b0;
    repeat (5) @(negedge clk);
    rx_line_s = 1'b1;
    repeat (3 * S_BAUD) @(negedge clk);
    m_rdy = 0;
    check("glitch.rdy", bus_s.rdy, m_rdy);
    check("glitch.frm", frm_s - f0, 0);
    send(0, 8'h5A, 1, -1, -1);
    model_frame(8'h5A, 1, -1);
    check_model("glitch.next");
    clr_pulse();

    // framing error, then line held low as a break
    f0 = frm_s; fl0 = frm_long_s;
    send(0, 8'h81, 0, -1, -1);
    model_frame(8'h81, 0, -1);
    check("frm.pulse", frm_s - f0, 1);
    repeat (10 * S_BAUD) @(negedge clk);
    rx_line_s = 1'b1;
    repeat (S_BAUD) @(negedge clk);
    check("frm.break", frm_s - f0, 1);
    check("frm.width", frm_long_s - fl0, 0);
    check_model("frm");

    // overrun, cleared by a single acknowledge
    send(0, 8'h11, 1, -1, -1);
    model_frame(8'h11, 1, -1);
    check_model("ovr.first");
    send(0, 8'h22, 1, -1, -1);
    model_frame(8'h22, 1, -1);
    check_model("ovr.second");
    check("ovr.flag", bus_s.ovr_err, 1'b1);
    clr_pulse();
    check("ovr.clr.rdy", bus_s.rdy, 1'b0);
    check("ovr.clr.ovr", bus_s.ovr_err, 1'b0);

    // acknowledge coinciding with the second completion
    send(0, 8'h11, 1, -1, -1);
    model_frame(8'h11, 1, -1);
    send(0, 8'h22, 1, S_LAT, -1);
    model_frame(8'h22, 1, S_LAT);
    check_model("coinc");
    check("coinc.rdy", bus_s.rdy, 1'b1);
    clr_pulse();

    // reset in the middle of data bit 4
    f0 = frm_s; r0 = rises_s;
    send(0, 8'hC3, 1, -1, 5 * S_BAUD + S_HALF);
    m_data = 8'h00;
    model_clear();
    repeat (12 * S_BAUD) @(negedge clk);
    check("rstmid.rises", rises_s - r0, 0);
    check("rstmid.frm", frm_s - f0, 0);
    check_model("rstmid");
    send(0, 8'h96, 1, -1, -1);
    model_frame(8'h96, 1, -1);
    check_model("rstmid.next");

    // randomized frames, errors and acknowledge timing
    for (int i = 0; i < 12; i++) begin
      logic [7:0] b;
      bit ok;
      int sel, cc;
      b   = 8'($urandom);
      ok  = ($urandom_range(0, 4) != 0);
      sel = int'($urandom_range(0, 2));
      cc  = (sel == 1) ? int'($urandom_range(0, 10 * S_BAUD - 1)) : -1;
      f0  = frm_s;
      send(0, b, ok, cc, -1);
      rx_line_s = 1'b1;
      model_frame(b, ok, cc);
      check_model("rnd");
      check("rnd.frm", frm_s - f0, ok ? 0 : 1);
      if (sel == 2) clr_pulse();
      repeat (int'($urandom_range(1, 20))) @(negedge clk);
    end

    // full-rate instance: 19200 baud latency
    r0 = rises_f; f0 = frm_f;
    send(1, 8'hA5, 1, -1, -1);
    lat = edge_cycles(rise_t_f, t_fall);
    check("full.rises", rises_f - r0, 1);
    check("full.latency", (lat >= F_LAT - 1 && lat <= F_LAT + 1) ? F_LAT : lat, F_LAT);
    check("full.data", bus_f.rx_data, 8'hA5);
    check("full.rdy", bus_f.rdy, 1'b1);
    check("full.ovr", bus_f.ovr_err, 1'b0);
    check("full.frm", frm_f - f0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
